// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Shares one external 16-bit combinational barrel shifter between
//            two requesters (port 0 = execute stage, port 1 = helper unit).
//            A round-robin winner's operands are registered onto the shifter
//            inputs. The shifter result is captured one cycle later and
//            returned on the winner's own valid/ready response channel.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready [1:0]           request handshake per port
//            req_data0/1 [15:0], req_amt0/1 [3:0], req_mode0/1 [1:0]
//            rsp_valid/rsp_ready [1:0]           response handshake per port
//            rsp_data [15:0], rsp_zero            registered result and flag
//            sh_in [15:0], sh_val [3:0], sh_mode [1:0]  to shifter
//            sh_out [15:0]                        from shifter
// Revision : 1.0  initial release
// ============================================================================
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    input  logic [3:0]  req_amt0,
    input  logic [3:0]  req_amt1,
    input  logic [1:0]  req_mode0,
    input  logic [1:0]  req_mode1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic [15:0] sh_in,
    output logic [3:0]  sh_val,
    output logic [1:0]  sh_mode,
    input  logic [15:0] sh_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_owner;
    logic [15:0] r_op_data;
    logic [3:0]  r_op_amt;
    logic [1:0]  r_op_mode;
    logic [15:0] r_res;
    logic        r_zero;

    logic        w_any;
    logic        w_grant;
    logic        w_accept;

    // A lone requester wins outright; on contention the preferred port wins.
    assign w_any    = |req_valid;
    assign w_grant  = (req_valid == 2'b11) ? r_prio : req_valid[1];
    assign w_accept = (r_state == ST_IDLE) && w_any;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready   = w_grant ? 2'b10 : 2'b01;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = r_owner ? 2'b10 : 2'b01;
                // Only the owner's ready can retire the response.
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, ownership and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_op_data <= 16'h0000;
            r_op_amt  <= 4'h0;
            r_op_mode <= 2'b00;
            r_res     <= 16'h0000;
            r_zero    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_data <= w_grant ? req_data1 : req_data0;
                r_op_amt  <= w_grant ? req_amt1  : req_amt0;
                r_op_mode <= w_grant ? req_mode1 : req_mode0;
                r_owner   <= w_grant;
                r_prio    <= ~w_grant;
            end
            // Operands only move on accept, so sh_out is settled here.
            if (r_state == ST_SHIFT) begin
                r_res  <= sh_out;
                r_zero <= (sh_out == 16'h0000);
            end
        end
    end

    assign rsp_data = r_res;
    assign rsp_zero = r_zero;
    assign sh_in    = r_op_data;
    assign sh_val   = r_op_amt;
    assign sh_mode  = r_op_mode;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Directed self-checking bench for shift_arbiter. Includes a
//            behavioural model of the external barrel shifter.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [3:0]  req_amt0;
    logic [3:0]  req_amt1;
    logic [1:0]  req_mode0;
    logic [1:0]  req_mode1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic [15:0] sh_in;
    logic [3:0]  sh_val;
    logic [1:0]  sh_mode;
    logic [15:0] sh_out;

    int n_checks;
    int n_errors;

    shift_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_amt0  (req_amt0),
        .req_amt1  (req_amt1),
        .req_mode0 (req_mode0),
        .req_mode1 (req_mode1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .sh_in     (sh_in),
        .sh_val    (sh_val),
        .sh_mode   (sh_mode),
        .sh_out    (sh_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shifter: 00 SLL, 01 SRA, 1x ROR.
    logic [31:0] w_rot;
    always_comb begin
        w_rot  = {sh_in, sh_in} >> sh_val;
        sh_out = 16'h0000;
        case (sh_mode)
            2'b00:   sh_out = sh_in << sh_val;
            2'b01:   sh_out = 16'($signed(sh_in) >>> sh_val);
            default: sh_out = w_rot[15:0];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic [15:0] d,
                           input logic [3:0] a, input logic [1:0] m);
        if (port) begin
            req_data1 = d; req_amt1 = a; req_mode1 = m;
        end else begin
            req_data0 = d; req_amt0 = a; req_mode0 = m;
        end
    endtask

    // Starts at a negedge with the DUT in IDLE and rsp_ready = 11; ends at
    // the negedge of the following IDLE cycle.
    task automatic single_op(input string tag, input logic port, input logic [15:0] d,
                             input logic [3:0] a, input logic [1:0] m,
                             input logic [15:0] exp, input logic expz);
        logic [1:0] mask;
        mask = port ? 2'b10 : 2'b01;
        set_req(port, d, a, m);
        req_valid = mask;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(mask));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check({tag, " sh_in"}, 32'(sh_in), 32'(d));
        @(negedge clk);
        check({tag, " shift rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(mask));
        check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp));
        check({tag, " rsp_zero"}, 32'(rsp_zero), 32'(expz));
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_req(1'b0, 16'h0, 4'h0, 2'b00);
        set_req(1'b1, 16'h0, 4'h0, 2'b00);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data",  32'(rsp_data),  32'd0);
        check("rst rsp_zero",  32'(rsp_zero),  32'd0);
        check("rst sh_all",    32'({sh_in, sh_val, sh_mode}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op and boundaries
        single_op("single",   1'b0, 16'h8001, 4'd1,  2'b01, 16'hC000, 1'b0);
        single_op("sra15",    1'b1, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0);
        single_op("sll8",     1'b0, 16'h00FF, 4'd8,  2'b00, 16'hFF00, 1'b0);
        single_op("ror0",     1'b1, 16'h1234, 4'd0,  2'b10, 16'h1234, 1'b0);
        single_op("zero",     1'b0, 16'h0000, 4'd0,  2'b00, 16'h0000, 1'b1);
        single_op("mode10",   1'b0, 16'h1234, 4'd4,  2'b10, 16'h4123, 1'b0);
        single_op("mode11",   1'b1, 16'h1234, 4'd4,  2'b11, 16'h4123, 1'b0);

        // Contention from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1'b0, 16'h0001, 4'd15, 2'b00);
        set_req(1'b1, 16'h0001, 4'd1,  2'b10);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] mask;
            mask = k[0] ? 2'b10 : 2'b01;
            check($sformatf("cont%0d req_ready", k), 32'(req_ready), 32'(mask));
            @(negedge clk);
            check($sformatf("cont%0d sh_mode", k), 32'(sh_mode), k[0] ? 32'd2 : 32'd0);
            @(negedge clk);
            check($sformatf("cont%0d rsp_valid", k), 32'(rsp_valid), 32'(mask));
            check($sformatf("cont%0d rsp_data", k), 32'(rsp_data), 32'h8000);
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
        end

        // Backpressure on port 1 with port 0 waiting
        set_req(1'b1, 16'h00F0, 4'd4, 2'b00);
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        #1;
        check("bp req_ready p1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        set_req(1'b0, 16'h0003, 4'd1, 2'b00);
        req_valid = 2'b01;
        @(negedge clk);
        check("bp shift req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'h2);
            check($sformatf("bp%0d rsp_data", i), 32'(rsp_data), 32'h0F00);
            check($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d sh_in", i), 32'(sh_in), 32'h00F0);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp next req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("bp p0 rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp p0 rsp_data", 32'(rsp_data), 32'h0006);
        @(negedge clk);

        // Withdrawn request: port 1 loses to port 0 and drops valid
        single_op("wd pre", 1'b1, 16'h0001, 4'd1, 2'b00, 16'h0002, 1'b0);
        set_req(1'b0, 16'h1111, 4'd0, 2'b00);
        set_req(1'b1, 16'h2222, 4'd3, 2'b01);
        req_valid = 2'b11;
        #1;
        check("wd req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("wd sh_in", 32'(sh_in), 32'h1111);
        @(negedge clk);
        @(negedge clk);
        check("wd rsp_valid", 32'(rsp_valid), 32'h1);
        check("wd rsp_data", 32'(rsp_data), 32'h1111);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("wd prio", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        #1;
        check("wd drop req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("wd idle req_ready", 32'(req_ready), 32'd0);
        check("wd idle sh_in", 32'(sh_in), 32'h1111);

        // Reset in the middle of RESP
        rsp_ready = 2'b00;
        set_req(1'b0, 16'h5555, 4'd1, 2'b00);
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("mid rsp_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid rst rsp_data", 32'(rsp_data), 32'd0);
        check("mid rst sh_in", 32'(sh_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        set_req(1'b1, 16'hF00F, 4'd4, 2'b10);
        req_valid = 2'b11;
        #1;
        check("mid prio", 32'(req_ready), 32'h1);
        req_valid = 2'b10;
        #1;
        check("mid p1 req_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("mid p1 rsp_valid", 32'(rsp_valid), 32'h2);
        check("mid p1 rsp_data", 32'(rsp_data), 32'hFF00);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
